uart_transmitter: RTL
=====================

# uart_transmitter

Serial UART transmitter sending 8-bit frames as start, 8 data bits LSB first, even parity, and stop. Bit timing runs at 16× oversample ticks derived from the 50 MHz system clock, with the same baud_sel encoding as the receive path. It is the transmit end of the team's UART link: its TxD drives a receiver's RxD directly. The frame format and timing are bit-exact with that receiver.

## Interface
- CLK_HZ, 50_000_000: system clock frequency; divisor table below assumes this value.
- OVERSAMPLE, 16: ticks per bit.
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- Tx_EN  in  1  transmitter enable; writes are ignored while low
- Tx_WR  in  1  single-cycle write strobe
- Tx_DATA  in  8  byte to send, sampled on the accepting cycle
- baud_sel  in  3  baud select, sampled on the accepting cycle
- TxD  out  1  serial line, idle high
- Tx_BUSY  out  1  high while a frame is in flight

## Operation
- Accept condition: Tx_WR=1, Tx_EN=1 and Tx_BUSY=0 on the same clock edge.
  - On accept, latch Tx_DATA and baud_sel.
  - On accept, compute parity = XOR of the 8 data bits; the frame therefore carries an even total count of ones over data+parity.
  - On accept, restart the tick divider.
- Tx_WR while busy, or while Tx_EN=0: ignored, no queueing, no error flag.
- baud_sel decode to 16× tick divisor, in clk cycles:
  - 000=10417 (300)
  - 001=2604 (1200)
  - 010=651 (4800)
  - 011=326 (9600)
  - 100=163 (19200)
  - 101=81 (38400)
  - 110=54 (57600)
  - 111=27 (115200)
- FSM states and transitions:
  - IDLE: TxD=1. Goes to START on accept.
  - START: TxD=0.
  - DATA: bit index 0..7, TxD=data[idx].
  - PARITY: TxD=parity.
  - STOP: TxD=1. Returns to IDLE.
- Each non-IDLE state, and each DATA index, lasts exactly 16 ticks. A 4-bit tick counter wraps 15→0 and advances the state or bit index on the wrap.
- Tx_EN deasserted mid-frame: the current frame completes normally; no new accepts afterwards.
- Input changes mid-frame on Tx_DATA or baud_sel: no effect, because the values were latched at accept.

## Timing
- Reset, synchronous: on the first rising edge with reset=1:
  - TxD=1, Tx_BUSY=0, FSM=IDLE.
  - Tick divider and counters cleared; data and parity registers cleared.
  - Reset mid-frame aborts the frame immediately; the line returns high at that edge.
- Accept at edge N: at edge N the FSM enters START, so TxD=0 and Tx_BUSY=1 are visible from edge N (registered outputs).
- Bit period B = 16×DIV clocks. The start bit occupies edges N … N+B−1, and data bit k begins at edge N+(k+1)·B.
- Parity begins at N+9B, stop at N+10B, and IDLE (Tx_BUSY=0) at N+11B.
- Frame length is exactly 11·B clocks, e.g. 4752 clocks at 115200.
- Back-to-back: a Tx_WR held high is accepted at edge N+11B+1, the first edge that sees Tx_BUSY=0. Minimum inter-frame idle is therefore one clock of TxD=1.
- Outputs are glitch-free registered signals. No combinational path runs from inputs to TxD or Tx_BUSY.

## Structure
- Shared package, uart_pkg:
  - state encoding, IDLE/START/DATA/PARITY/STOP
  - baud_sel-to-divisor constant function or table
  - OVERSAMPLE
  - frame-length constants
- The receive path reuses the same package so both ends stay consistent.
- One sub-module, uart_baud_tick: a synchronous divider producing a one-clk tick pulse.
  - Inputs: clk, reset, divisor, restart.
  - The tick is used as an enable, never as a clock.
- Top level holds the FSM, the shift/bit index, the tick counter and the output registers.

## Test plan
- Reset: hold reset 3 cycles mid-idle -> TxD=1, Tx_BUSY=0 after first reset edge. Repeat during a data bit -> TxD=1, Tx_BUSY=0 at that edge.
- Single frame, baud_sel=111, Tx_DATA=8'hA5:
  - Line sequence is 0,1,0,1,0,0,1,0,1 (start, then data LSB first), then parity 0, then stop 1.
  - Each bit lasts 432 clks; Tx_BUSY stays high for exactly 4752 clks.
- Parity, baud_sel=011, Tx_DATA=8'h01: parity bit=1, bit period 5216 clks. Tx_DATA=8'h00: parity=0.
- Write handling:
  - Tx_WR pulsed with Tx_EN=0 -> no frame.
  - Tx_WR during busy with 8'hFF while sending 8'h3C -> only 8'h3C sent.
  - Tx_WR held high over two frames -> second frame starts exactly one clock of idle after the first stop bit ends.
- Latching: change Tx_DATA and baud_sel one cycle after accept -> the frame uses the original values. Drop Tx_EN mid-frame -> the frame completes.
- Loopback: TxD into the team UART receiver for all 8 baud_sel values with random bytes -> received data matches and Rx_VALID=1, with no parity or framing errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling, baud divisor
// table and frame geometry. Used by both the transmit and receive paths.
package uart_pkg;

  localparam int CLK_HZ     = 50_000_000;
  localparam int OVERSAMPLE = 16;
  localparam int DIV_W      = 14;
  localparam int DATA_BITS  = 8;
  // start + data + parity + stop
  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Rounded clk cycles per oversample tick for a given baud rate.
  function automatic int calc_div(input int baud);
    return (CLK_HZ + (OVERSAMPLE * baud) / 32'sd2) / (OVERSAMPLE * baud);
  endfunction

  localparam logic [DIV_W-1:0] DIV_300    = DIV_W'(calc_div(32'sd300));
  localparam logic [DIV_W-1:0] DIV_1200   = DIV_W'(calc_div(32'sd1200));
  localparam logic [DIV_W-1:0] DIV_4800   = DIV_W'(calc_div(32'sd4800));
  localparam logic [DIV_W-1:0] DIV_9600   = DIV_W'(calc_div(32'sd9600));
  localparam logic [DIV_W-1:0] DIV_19200  = DIV_W'(calc_div(32'sd19200));
  localparam logic [DIV_W-1:0] DIV_38400  = DIV_W'(calc_div(32'sd38400));
  localparam logic [DIV_W-1:0] DIV_57600  = DIV_W'(calc_div(32'sd57600));
  localparam logic [DIV_W-1:0] DIV_115200 = DIV_W'(calc_div(32'sd115200));

  // baud_sel to oversample tick divisor (clk cycles per tick).
  function automatic logic [DIV_W-1:0] baud_divisor(input logic [2:0] sel);
    logic [DIV_W-1:0] div;
    case (sel)
      3'b000:  div = DIV_300;
      3'b001:  div = DIV_1200;
      3'b010:  div = DIV_4800;
      3'b011:  div = DIV_9600;
      3'b100:  div = DIV_19200;
      3'b101:  div = DIV_38400;
      3'b110:  div = DIV_57600;
      3'b111:  div = DIV_115200;
      default: div = DIV_115200;
    endcase
    return div;
  endfunction

  // Even parity bit: makes the ones count over data+parity even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

  // Full frame duration in clk cycles for a given baud_sel.
  function automatic int unsigned frame_clocks(input logic [2:0] sel);
    return FRAME_BITS * OVERSAMPLE * int'(baud_divisor(sel));
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk enable pulse every 'divisor' clocks,
// realigned to the restart strobe so a frame starts on a clean tick boundary.
module uart_baud_tick
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] divisor,
  input  logic             restart,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_r;
  logic             tick_r;

  // Divide clk by 'divisor'; the registered tick lands on the last cycle of each period.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (restart) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      if (cnt_r >= divisor - 14'd1) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + 14'd1;
      end
      tick_r <= (cnt_r == divisor - 14'd2);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 8 data bits LSB first, even parity, stop.
// Each bit spans OVERSAMPLE ticks of the baud divider; TxD and Tx_BUSY are
// registered so the line never glitches.
module uart_transmitter
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  input  logic [2:0] baud_sel,
  output logic       TxD,
  output logic       Tx_BUSY
);

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  uart_state_e      state_r, state_s;
  logic [2:0]       bit_idx_r, bit_idx_s;
  logic [3:0]       tick_cnt_r, tick_cnt_s;
  logic [7:0]       data_r, data_s;
  logic             parity_r, parity_s;
  logic [2:0]       baud_r, baud_s;
  logic             txd_r, busy_r;
  logic             line_s, busy_s;
  logic             accept_s;
  logic             tick_s;
  logic [DIV_W-1:0] divisor_s;

  // A write is taken only when enabled and no frame is in flight.
  assign accept_s  = Tx_WR && Tx_EN && !busy_r;
  assign divisor_s = baud_divisor(baud_r);

  uart_baud_tick u_baud_tick (
    .clk     (clk),
    .reset   (reset),
    .divisor (divisor_s),
    .restart (accept_s),
    .tick    (tick_s)
  );

  // Next-state logic: latch the frame on accept, advance on each 16th tick.
  always_comb begin
    state_s    = state_r;
    bit_idx_s  = bit_idx_r;
    tick_cnt_s = tick_cnt_r;
    data_s     = data_r;
    parity_s   = parity_r;
    baud_s     = baud_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s    = ST_START;
          bit_idx_s  = 3'd0;
          tick_cnt_s = 4'd0;
          data_s     = Tx_DATA;
          parity_s   = even_parity(Tx_DATA);
          baud_s     = baud_sel;
        end else begin
          tick_cnt_s = 4'd0;
        end
      end
      ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
        if (tick_s) begin
          if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_s = 4'd0;
            case (state_r)
              ST_START: begin
                state_s   = ST_DATA;
                bit_idx_s = 3'd0;
              end
              ST_DATA: begin
                if (bit_idx_r == BIT_LAST) begin
                  state_s = ST_PARITY;
                end else begin
                  bit_idx_s = bit_idx_r + 3'd1;
                end
              end
              ST_PARITY: state_s = ST_STOP;
              ST_STOP:   state_s = ST_IDLE;
              default:   state_s = ST_IDLE;
            endcase
          end else begin
            tick_cnt_s = tick_cnt_r + 4'd1;
          end
        end else begin
          tick_cnt_s = tick_cnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Line level and busy flag for the upcoming state, registered below.
  always_comb begin
    line_s = 1'b1;
    busy_s = 1'b1;
    case (state_s)
      ST_IDLE: begin
        line_s = 1'b1;
        busy_s = 1'b0;
      end
      ST_START:  line_s = 1'b0;
      ST_DATA:   line_s = data_s[bit_idx_s];
      ST_PARITY: line_s = parity_s;
      ST_STOP:   line_s = 1'b1;
      default: begin
        line_s = 1'b1;
        busy_s = 1'b0;
      end
    endcase
  end

  // State, frame registers and output flops; reset aborts any frame at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      bit_idx_r  <= 3'd0;
      tick_cnt_r <= 4'd0;
      data_r     <= 8'd0;
      parity_r   <= 1'b0;
      baud_r     <= 3'd0;
      txd_r      <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      bit_idx_r  <= bit_idx_s;
      tick_cnt_r <= tick_cnt_s;
      data_r     <= data_s;
      parity_r   <= parity_s;
      baud_r     <= baud_s;
      txd_r      <= line_s;
      busy_r     <= busy_s;
    end
  end

  assign TxD     = txd_r;
  assign Tx_BUSY = busy_r;

endmodule
